// File: rtl/inner_prod_sched.sv
// inner_prod_sched: round-robin scheduler sharing one Inner_Prod engine among NUM_REQ requesters.
// A granted requester's VLEN-element A/B vectors are streamed into the engine one element per
// cycle. The engine result is captured and returned to that requester with a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset (shared with the engine)
//   req             per-requester job request (level, held until done)
//   req_a, req_b    flattened per-requester A/B elements, slice i is [i*DW +: DW]
//   beat_idx        element index the granted requester must present this cycle
//   grant           one-hot grant, high for the whole job
//   done            one-hot, one-cycle pulse when result is valid for that requester
//   result          captured inner product, held until the next capture
//   err             one-cycle timeout flag, coincident with done
//   eng_valid_in    engine valid_in
//   eng_A, eng_B    engine operands
//   eng_valid_out   engine valid_out
//   eng_C           engine result
//
// Optional feature: define IP_TIMEOUT_EN to bound WAIT to TIMEOUT cycles. On expiry the job
// retires with result=0 and err pulsing together with done. Without it WAIT waits forever.
module inner_prod_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned CW      = 19,
    parameter int unsigned VLEN    = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic [2:0]            beat_idx,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic [CW-1:0]         result,
    output logic                  err,
    output logic                  eng_valid_in,
    output logic [DW-1:0]         eng_A,
    output logic [DW-1:0]         eng_B,
    input  logic                  eng_valid_out,
    input  logic [CW-1:0]         eng_C
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StStream, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      win_q, win_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [2:0]         beat_q, beat_d;
    logic [CW-1:0]      result_q, result_d;

`ifdef IP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timed_out_q, timed_out_d;
`endif

    // Round-robin pick: first requester at or after ptr_q, with wraparound.
    int unsigned   cand;
    logic [PW-1:0] cand_idx;
    logic [PW-1:0] pick_idx;
    logic          pick_vld;

    always_comb begin
        cand     = 0;
        cand_idx = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(ptr_q) + i) % NUM_REQ;
            cand_idx = PW'(cand);
            if (!pick_vld && req[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            win_q       <= '0;
            grant_q     <= '0;
            beat_q      <= '0;
            result_q    <= '0;
`ifdef IP_TIMEOUT_EN
            wait_cnt_q  <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            grant_q     <= grant_d;
            beat_q      <= beat_d;
            result_q    <= result_d;
`ifdef IP_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        grant_d     = grant_q;
        beat_d      = beat_q;
        result_d    = result_q;
`ifdef IP_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        timed_out_d = timed_out_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    state_d           = StStream;
                    win_d             = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    beat_d            = '0;
`ifdef IP_TIMEOUT_EN
                    timed_out_d       = 1'b0;
`endif
                end
            end
            StStream: begin
                if (beat_q == 3'(VLEN - 1)) begin
                    state_d    = StWait;
                    beat_d     = '0;
`ifdef IP_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            StWait: begin
                if (eng_valid_out) begin
                    result_d = eng_C;
                    state_d  = StDone;
`ifdef IP_TIMEOUT_EN
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    // Engine never answered: retire the job with a zero result.
                    result_d    = '0;
                    timed_out_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            StDone: begin
                // No arbitration here, so a requester can drop req before being looked at again.
                state_d     = StIdle;
                grant_d     = '0;
                ptr_d       = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`ifdef IP_TIMEOUT_EN
                timed_out_d = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        beat_idx     = beat_q;
        grant        = grant_q;
        result       = result_q;
        eng_valid_in = (state_q == StStream);
        done         = (state_q == StDone) ? grant_q : '0;
`ifdef IP_TIMEOUT_EN
        err          = (state_q == StDone) && timed_out_q;
`else
        err          = 1'b0;
`endif
        eng_A        = '0;
        eng_B        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                eng_A = eng_A | req_a[i*DW +: DW];
                eng_B = eng_B | req_b[i*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_inner_prod_sched.sv
// Self-checking bench for inner_prod_sched: directed jobs plus randomized request masks and
// operand vectors, checked against dot products and a round-robin pick computed in the bench.
// The engine model accumulates VLEN beats and presents C two cycles after the last beat.
module tb_inner_prod_sched;

    localparam int NR = 4;
    localparam int VL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [31:0]   req_a, req_b;
    logic [2:0]    beat_idx;
    logic [3:0]    grant, done;
    logic [18:0]   result;
    logic          err, eng_valid_in;
    logic [7:0]    eng_A, eng_B;
    logic          eng_valid_out;
    logic [18:0]   eng_C;

    logic [7:0] va [NR][VL];
    logic [7:0] vb [NR][VL];

    int n_checks = 0;
    int n_errs   = 0;
    int mptr     = 0;
    bit mute     = 1'b0;

    inner_prod_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_a        (req_a),
        .req_b        (req_b),
        .beat_idx     (beat_idx),
        .grant        (grant),
        .done         (done),
        .result       (result),
        .err          (err),
        .eng_valid_in (eng_valid_in),
        .eng_A        (eng_A),
        .eng_B        (eng_B),
        .eng_valid_out(eng_valid_out),
        .eng_C        (eng_C)
    );

    always #5 clk = ~clk;

    // Every requester presents element beat_idx of its own vectors.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_a[i*8 +: 8] = va[i][beat_idx];
            req_b[i*8 +: 8] = vb[i][beat_idx];
        end
    end

    // Engine model: accumulate VL beats, stage the sum, then present it.
    logic [18:0] acc, stage;
    logic        stage_v;
    int          ecnt;
    always @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            ecnt          <= 0;
            stage_v       <= 1'b0;
            eng_valid_out <= 1'b0;
            eng_C         <= '0;
        end else begin
            eng_valid_out <= 1'b0;
            stage_v       <= 1'b0;
            if (eng_valid_in) begin
                if (ecnt == VL - 1) begin
                    stage   <= acc + 19'(eng_A) * 19'(eng_B);
                    stage_v <= 1'b1;
                    acc     <= '0;
                    ecnt    <= 0;
                end else begin
                    acc  <= acc + 19'(eng_A) * 19'(eng_B);
                    ecnt <= ecnt + 1;
                end
            end
            if (stage_v && !mute) begin
                eng_valid_out <= 1'b1;
                eng_C         <= stage;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < NR; i++) begin
            if (r[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    function automatic int dot(input int w);
        int s = 0;
        for (int k = 0; k < VL; k++) s += int'(va[w][k]) * int'(vb[w][k]);
        return s;
    endfunction

    task automatic randomize_vectors();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < VL; k++) begin
                va[i][k] = 8'($urandom_range(0, 255));
                vb[i][k] = 8'($urandom_range(0, 255));
            end
    endtask

    task automatic fill(input int w, input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < VL; k++) begin
            va[w][k] = a;
            vb[w][k] = b;
        end
    endtask

    // Follow one job from grant to done. The expected winner comes from the current req and
    // the bench's pointer; add_mask raises extra requests once the grant is seen.
    task automatic run_job(input logic [3:0] add_mask, input string tag);
        int         w, gcnt, vcnt;
        bit         beat_ok, hold_ok;
        logic [3:0] oh;
        w  = pick(req, mptr);
        oh = 4'b0001 << w;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (grant != 4'b0) break;
        end
        check({tag, " grant"}, 32'(grant), 32'(oh));
        req     = req | add_mask;
        gcnt    = 0;
        vcnt    = 0;
        beat_ok = 1'b1;
        hold_ok = 1'b1;
        for (int n = 0; n < 80 && done == 4'b0; n++) begin
            if (grant !== oh) hold_ok = 1'b0;
            gcnt++;
            if (eng_valid_in) begin
                if (beat_idx !== 3'(vcnt)) beat_ok = 1'b0;
                vcnt++;
            end
            @(negedge clk);
        end
        check({tag, " done"}, 32'(done), 32'(oh));
        check({tag, " result"}, 32'(result), 32'(dot(w)));
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " job cycles"}, 32'(gcnt), 32'd10);
        check({tag, " beats"}, 32'(vcnt), 32'(VL));
        check({tag, " beat order"}, 32'(beat_ok), 32'd1);
        check({tag, " grant held"}, 32'(hold_ok), 32'd1);
        req[w] = 1'b0;
        mptr   = (w + 1) % NR;
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " grant clear"}, 32'(grant), 32'd0);
        check({tag, " valid gap"}, 32'(eng_valid_in), 32'd0);
    endtask

    initial begin
        int  nd;
        bit  hit;
        rst = 1'b1;
        req = 4'b0;
        for (int i = 0; i < NR; i++) fill(i, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("rst grant", 32'(grant), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst beat_idx", 32'(beat_idx), 32'd0);
        check("rst valid_in", 32'(eng_valid_in), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single job, constant operands.
        fill(1, 8'd3, 8'd5);
        req = 4'b0010;
        run_job(4'b0, "single");

        // Largest operands on requester 0.
        fill(0, 8'd255, 8'd255);
        req = 4'b0001;
        run_job(4'b0, "max");

        // Contention from reset.
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        mptr = 0;
        randomize_vectors();
        req = 4'b1111;
        for (int j = 0; j < 4; j++) run_job(4'b0, "contend");

        // Fairness: 0 and 3 arrive while 2 is busy.
        req = 4'b0100;
        run_job(4'b1001, "fair2");
        run_job(4'b0, "fair3");
        run_job(4'b0, "fair0");

        // Random request masks and operands.
        for (int r = 0; r < 6; r++) begin
            randomize_vectors();
            req = 4'($urandom_range(1, 15));
            while (req != 4'b0) run_job(4'b0, "rnd");
        end

        // Move the pointer off zero, then reset in the middle of a stream.
        req = 4'b0010;
        run_job(4'b0, "pre_rst");
        req = 4'b1000;
        hit = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (eng_valid_in && beat_idx == 3'd4) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach beat 4", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst grant", 32'(grant), 32'd0);
        check("mid rst valid_in", 32'(eng_valid_in), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        rst  = 1'b0;
        req  = 4'b0000;
        mptr = 0;
        nd   = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done != 4'b0) nd++;
        end
        check("aborted no done", 32'(nd), 32'd0);
        // Pointer back at 0: requester 1 wins over 2.
        randomize_vectors();
        req = 4'b0110;
        run_job(4'b0, "post_rst1");
        run_job(4'b0, "post_rst2");

`ifdef IP_TIMEOUT_EN
        begin
            int gcnt;
            mute = 1'b1;
            req  = 4'b0001;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (grant != 4'b0) break;
            end
            gcnt = 0;
            for (int n = 0; n < 80 && done == 4'b0; n++) begin
                gcnt++;
                @(negedge clk);
            end
            check("tmo done", 32'(done), 32'd1);
            check("tmo err", 32'(err), 32'd1);
            check("tmo result", 32'(result), 32'd0);
            check("tmo cycles", 32'(gcnt), 32'(VL + 16));
            req = 4'b0;
            @(negedge clk);
            check("tmo err pulse", 32'(err), 32'd0);
            check("tmo grant clear", 32'(grant), 32'd0);
            mute = 1'b0;
            mptr = 1;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
